// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, S-boxes, FSM encodings and the
// bit-manipulation helpers used by the round engine and its f-function.
package des_pkg;

  localparam int DES_ROUNDS = 16;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t ROUND = 2'd1;
  localparam state_t DONE  = 2'd2;

  // Tables list DES bit numbers (1 = MSB) in output order.
  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  // Indexed by {b1, b6, b2..b5}: row in the upper two bits, column below.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [63:0] des_ip(input logic [63:0] d);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - IP_TAB[6'(i)])];
    return o;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] d);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - FP_TAB[6'(i)])];
    return o;
  endfunction

  function automatic logic [47:0] des_e(input logic [31:0] d);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = d[5'(32 - E_TAB[6'(i)])];
    return o;
  endfunction

  function automatic logic [31:0] des_p(input logic [31:0] d);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o[5'(31 - i)] = d[5'(32 - P_TAB[5'(i)])];
    return o;
  endfunction

  // idx is the 1-based subkey number; K1 lives in the least significant slice.
  function automatic logic [47:0] subkey_sel(input logic [767:0] keys, input logic [4:0] idx);
    logic [47:0] k;
    k = '0;
    for (int j = 0; j < 16; j++) begin
      if (idx == 5'(j + 1)) k = keys[10'(j * 48) +: 48];
    end
    return k;
  endfunction

endpackage

// File: rtl/des_round_engine_if.sv
// Block/handshake bundle between the key-schedule side, the round engine
// and the downstream consumer.
interface des_round_engine_if;
  import des_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic         decrypt;
  logic [63:0]  block_in;
  logic [767:0] subkeys;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  block_out;

  modport master (
    output in_valid, decrypt, block_in, subkeys, out_ready,
    input  in_ready, out_valid, block_out
  );

  modport slave (
    input  in_valid, decrypt, block_in, subkeys, out_ready,
    output in_ready, out_valid, block_out
  );
endinterface

// File: rtl/des_f_function.sv
// DES round function: expand R, mix in the round key, S-box substitute and
// permute. Purely combinational.
module des_f_function
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f
);

  logic [47:0] x;
  logic [31:0] s_out;

  assign x = des_e(r) ^ k;

  for (genvar gi = 0; gi < 8; gi++) begin : g_sbox
    logic [5:0] six;
    assign six = x[47 - 6*gi -: 6];
    // Outer bits pick the row, inner four the column.
    assign s_out[31 - 4*gi -: 4] = 4'(SBOX[gi][{six[5], six[0], six[4:1]}]);
  end

  assign f = des_p(s_out);

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES engine: one Feistel round per clock, one block in flight,
// valid/ready on both sides. Subkeys come straight from the key schedule.
module des_round_engine
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = DES_ROUNDS
) (
  input logic                clk,
  input logic                rst,
  des_round_engine_if.slave  bus
);

  if (NUM_ROUNDS != DES_ROUNDS) begin : g_bad_rounds
    $error("des_round_engine: NUM_ROUNDS must be 16");
  end

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] l_reg, l_next;
  logic [31:0] r_reg, r_next;
  logic        mode_reg, mode_next;
  logic [63:0] out_reg, out_next;

  logic [4:0]  key_idx;
  logic [47:0] round_key;
  logic [31:0] f_out;
  logic [63:0] ip_block;
  logic        last_round;

  // Decryption walks the same schedule backwards: K16 first.
  assign key_idx    = mode_reg ? (5'd16 - {1'b0, cnt_reg}) : ({1'b0, cnt_reg} + 5'd1);
  assign round_key  = subkey_sel(bus.subkeys, key_idx);
  assign ip_block   = des_ip(bus.block_in);
  assign last_round = (cnt_reg == 4'(NUM_ROUNDS - 1));

  des_f_function u_f (
    .r (r_reg),
    .k (round_key),
    .f (f_out)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    l_next     = l_reg;
    r_next     = r_reg;
    mode_next  = mode_reg;
    out_next   = out_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          {l_next, r_next} = ip_block;
          mode_next        = bus.decrypt;
          cnt_next         = 4'd0;
          state_next       = ROUND;
        end
      end
      ROUND: begin
        l_next = r_reg;
        r_next = l_reg ^ f_out;
        if (last_round) begin
          // Final swap: output is FP({R16, L16}).
          out_next   = des_fp({l_reg ^ f_out, r_reg});
          cnt_next   = 4'd0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      l_reg     <= '0;
      r_reg     <= '0;
      mode_reg  <= 1'b0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      l_reg     <= l_next;
      r_reg     <= r_next;
      mode_reg  <= mode_next;
      out_reg   <= out_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.block_out = out_reg;

endmodule
